// File: rtl/draw_sched_pkg.sv
// Shared types and client index map for the frame draw scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package draw_sched_pkg;

    // Scheduler phases: wait for vsync, pick a client, serve it, wait for its done to drop, end of frame
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        GRANT = 3'd2,
        ACK   = 3'd3,
        FDONE = 3'd4
    } sched_state_e;

    localparam int N_SPRITE_DEF = 4;
    localparam int NC_DEF       = N_SPRITE_DEF + 2;

    // Painter's order is plain ascending index: map first, sprites next, HUD last
    localparam int CLIENT_MAP   = 0;
    localparam int CLIENT_SPR0  = 1;
    localparam int CLIENT_HUD   = NC_DEF - 1;

endpackage

// File: rtl/draw_port_mux.sv
// Forwards the granted client's x/y/colour/write onto the single VGA write port.
// Latency: purely combinational from the registered grant index.
// Backpressure: none; outputs are forced to zero whenever valid_i is low.
module draw_port_mux #(
    parameter int NC  = 6,
    parameter int X_W = 9,
    parameter int Y_W = 8,
    parameter int C_W = 6,
    localparam int GW = (NC > 1) ? $clog2(NC) : 1
) (
    input  logic              valid_i,
    input  logic [GW-1:0]     grant_idx_i,
    input  logic [NC*X_W-1:0] client_x_i,
    input  logic [NC*Y_W-1:0] client_y_i,
    input  logic [NC*C_W-1:0] client_colour_i,
    input  logic [NC-1:0]     client_write_i,
    output logic [X_W-1:0]    vga_x_o,
    output logic [Y_W-1:0]    vga_y_o,
    output logic [C_W-1:0]    vga_colour_o,
    output logic              vga_write_o
);

    // Select the granted client's fields; nothing leaks through outside a grant
    always_comb begin
        vga_x_o      = '0;
        vga_y_o      = '0;
        vga_colour_o = '0;
        vga_write_o  = 1'b0;
        if (valid_i) begin
            vga_x_o      = client_x_i[grant_idx_i*X_W +: X_W];
            vga_y_o      = client_y_i[grant_idx_i*Y_W +: Y_W];
            vga_colour_o = client_colour_i[grant_idx_i*C_W +: C_W];
            vga_write_o  = client_write_i[grant_idx_i];
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer/arbiter granting the VGA write port to map, sprites, HUD in turn.
// Latency: enable rises two edges after frame_start is sampled; >=2 idle cycles between grants.
// Backpressure: waits on each client's done (then its release); a watchdog aborts stuck grants.
module draw_scheduler
    import draw_sched_pkg::*;
#(
    parameter int N_SPRITE  = N_SPRITE_DEF,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int C_W       = 6,
    parameter int MAX_GRANT = 65535,
    localparam int NC       = N_SPRITE + 2,
    localparam int GW       = (NC > 1) ? $clog2(NC) : 1,
    localparam int WD_W     = $clog2(MAX_GRANT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_start_i,
    input  logic [NC-1:0]     client_req_i,
    input  logic [NC-1:0]     client_done_i,
    input  logic [NC*X_W-1:0] client_x_i,
    input  logic [NC*Y_W-1:0] client_y_i,
    input  logic [NC*C_W-1:0] client_colour_i,
    input  logic [NC-1:0]     client_write_i,
    output logic [NC-1:0]     client_enable_o,
    output logic [X_W-1:0]    vga_x_o,
    output logic [Y_W-1:0]    vga_y_o,
    output logic [C_W-1:0]    vga_colour_o,
    output logic              vga_write_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic              timeout_err_o
);

    sched_state_e    state_q, state_d;
    logic [NC-1:0]   pending_q, pending_d;
    logic [NC-1:0]   enable_q, enable_d;
    logic [GW-1:0]   grant_idx_q, grant_idx_d;
    logic [GW-1:0]   low_idx;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            frame_done_q, frame_done_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;
    logic            granted_done;
    logic            wd_expired;
    logic            mux_vld;

    assign granted_done = client_done_i[grant_idx_q];
    assign wd_expired   = (wd_cnt_q == WD_W'(MAX_GRANT - 1));
    assign mux_vld      = (state_q == GRANT);

    // Lowest pending index: scanning downward lets the lowest set bit win
    always_comb begin
        low_idx = '0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                low_idx = GW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: done beats the watchdog; ACK holds until the old client releases done
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_start_i) state_d = SCAN;
            SCAN:    state_d = (pending_q == '0) ? FDONE : GRANT;
            GRANT:   if (granted_done || wd_expired) state_d = ACK;
            ACK:     if (!granted_done) state_d = SCAN;
            FDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: pending bookkeeping, enable, watchdog and sticky flags
    always_comb begin
        pending_d    = pending_q;
        grant_idx_d  = grant_idx_q;
        enable_d     = enable_q;
        wd_cnt_d     = wd_cnt_q;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q | (frame_start_i && (state_q != IDLE));
        timeout_d    = timeout_q;
        case (state_q)
            IDLE: begin
                if (frame_start_i) begin
                    pending_d = client_req_i;
                end
            end
            SCAN: begin
                if (pending_q != '0) begin
                    grant_idx_d = low_idx;
                    enable_d    = NC'(1) << low_idx;
                    wd_cnt_d    = '0;
                end else begin
                    frame_done_d = 1'b1;
                end
            end
            GRANT: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                if (granted_done) begin
                    pending_d[grant_idx_q] = 1'b0;
                    enable_d               = '0;
                end else if (wd_expired) begin
                    timeout_d              = 1'b1;
                    pending_d[grant_idx_q] = 1'b0;
                    enable_d               = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset discards all pending work and drops enable at once
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q    <= '0;
            grant_idx_q  <= '0;
            enable_q     <= '0;
            wd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            grant_idx_q  <= grant_idx_d;
            enable_q     <= enable_d;
            wd_cnt_q     <= wd_cnt_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign client_enable_o = enable_q;
    assign busy_o          = (state_q != IDLE);
    assign frame_done_o    = frame_done_q;
    assign overrun_o       = overrun_q;
    assign timeout_err_o   = timeout_q;

    draw_port_mux #(
        .NC  (NC),
        .X_W (X_W),
        .Y_W (Y_W),
        .C_W (C_W)
    ) u_port_mux (
        .valid_i         (mux_vld),
        .grant_idx_i     (grant_idx_q),
        .client_x_i      (client_x_i),
        .client_y_i      (client_y_i),
        .client_colour_i (client_colour_i),
        .client_write_i  (client_write_i),
        .vga_x_o         (vga_x_o),
        .vga_y_o         (vga_y_o),
        .vga_colour_o    (vga_colour_o),
        .vga_write_o     (vga_write_o)
    );

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: per-frame timeline model plus a per-cycle compare process.
// Latency: n/a.
// Backpressure: n/a.
module tb_draw_scheduler;

    localparam int N_SPRITE  = 4;
    localparam int NC        = N_SPRITE + 2;
    localparam int X_W       = 9;
    localparam int Y_W       = 8;
    localparam int C_W       = 6;
    localparam int MAX_GRANT = 65535;
    localparam int INF       = 32'h7fff_ffff;

    logic              clock = 1'b0;
    logic              reset;
    logic              frame_start;
    logic [NC-1:0]     client_req;
    logic [NC-1:0]     client_done;
    logic [NC*X_W-1:0] client_x;
    logic [NC*Y_W-1:0] client_y;
    logic [NC*C_W-1:0] client_colour;
    logic [NC-1:0]     client_write;
    logic [NC-1:0]     client_enable;
    logic [X_W-1:0]    vga_x;
    logic [Y_W-1:0]    vga_y;
    logic [C_W-1:0]    vga_colour;
    logic              vga_write;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              timeout_err;

    draw_scheduler #(
        .N_SPRITE  (N_SPRITE),
        .X_W       (X_W),
        .Y_W       (Y_W),
        .C_W       (C_W),
        .MAX_GRANT (MAX_GRANT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .frame_start_i   (frame_start),
        .client_req_i    (client_req),
        .client_done_i   (client_done),
        .client_x_i      (client_x),
        .client_y_i      (client_y),
        .client_colour_i (client_colour),
        .client_write_i  (client_write),
        .client_enable_o (client_enable),
        .vga_x_o         (vga_x),
        .vga_y_o         (vga_y),
        .vga_colour_o    (vga_colour),
        .vga_write_o     (vga_write),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .overrun_o       (overrun),
        .timeout_err_o   (timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model expectations for the current cycle
    logic [NC-1:0] exp_en;
    bit            exp_busy, exp_fd, exp_vld;
    int            exp_idx;
    int            ovr_cyc = INF;
    int            to_cyc  = INF;
    bit            cmp_en  = 1'b0;

    // Per-frame observations used by the literal checks
    logic [NC-1:0] en_seq[$];
    int            rise_q[$];
    int            fd_count, fd_off, frame_base;
    logic [NC-1:0] last_en = '0;

    // Per-client plan: done delay after enable (-1 = never) and done hold after enable drops
    int fr_d[NC];
    int fr_h[NC];

    logic [X_W-1:0] ex_x;
    logic [Y_W-1:0] ex_y;
    logic [C_W-1:0] ex_c;
    logic           ex_w;

    // Compare DUT outputs against the model on every cycle
    always @(negedge clock) begin
        if (cmp_en) begin
            ex_x = '0; ex_y = '0; ex_c = '0; ex_w = 1'b0;
            if (exp_vld) begin
                ex_x = client_x[exp_idx*X_W +: X_W];
                ex_y = client_y[exp_idx*Y_W +: Y_W];
                ex_c = client_colour[exp_idx*C_W +: C_W];
                ex_w = client_write[exp_idx];
            end
            check("client_enable", 64'(client_enable), 64'(exp_en));
            check("busy",          64'(busy),          64'(exp_busy));
            check("frame_done",    64'(frame_done),    64'(exp_fd));
            check("overrun",       64'(overrun),       64'(cyc >= ovr_cyc));
            check("timeout_err",   64'(timeout_err),   64'(cyc >= to_cyc));
            check("vga_x",         64'(vga_x),         64'(ex_x));
            check("vga_y",         64'(vga_y),         64'(ex_y));
            check("vga_colour",    64'(vga_colour),    64'(ex_c));
            check("vga_write",     64'(vga_write),     64'(ex_w));
            if (client_enable != '0 && last_en == '0) begin
                en_seq.push_back(client_enable);
                rise_q.push_back(cyc - frame_base);
            end
            if (frame_done) begin
                fd_count++;
                if (fd_off < 0) fd_off = cyc - frame_base;
            end
            last_en = client_enable;
        end
    end

    task automatic drive_fields();
        for (int i = 0; i < NC; i++) begin
            client_x[i*X_W +: X_W]      = X_W'($urandom);
            client_y[i*Y_W +: Y_W]      = Y_W'($urandom);
            client_colour[i*C_W +: C_W] = C_W'($urandom);
            client_write[i]             = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n, input bit clr_flags);
        repeat (n) begin
            @(posedge clock); #1;
            reset       = 1'b0;
            frame_start = 1'b0;
            client_req  = NC'($urandom);
            client_done = NC'($urandom);
            drive_fields();
            exp_en = '0; exp_vld = 1'b0; exp_idx = 0; exp_busy = 1'b0; exp_fd = 1'b0;
            if (clr_flags) begin
                ovr_cyc = INF;
                to_cyc  = INF;
            end
        end
    endtask

    task automatic clear_plan();
        for (int k = 0; k < NC; k++) begin
            fr_d[k] = 0;
            fr_h[k] = 0;
        end
    endtask

    // One frame: offset 0 is the cycle frame_start is high. Each requested client in
    // ascending order gets enable over [gs, ge]; the next grant starts hold+3 cycles later.
    task automatic run_frame(input logic [NC-1:0] req, input int ovr_sel, input int rst_at, input bit wr_ng);
        int gs[NC];
        int ge[NC];
        bit tmo[NC];
        int t, fd, ovr_at;
        t = 2;
        for (int k = 0; k < NC; k++) begin
            gs[k] = -1; ge[k] = -2; tmo[k] = 1'b0;
            if (req[k]) begin
                gs[k] = t;
                if (fr_d[k] < 0 || fr_d[k] >= MAX_GRANT) begin
                    tmo[k] = 1'b1;
                    ge[k]  = t + MAX_GRANT - 1;
                    t      = ge[k] + 3;
                end else begin
                    ge[k] = t + fr_d[k];
                    t     = ge[k] + fr_h[k] + 3;
                end
            end
        end
        fd     = t;
        ovr_at = ovr_sel;
        if (ovr_sel == -2) begin
            ovr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, fd)) : -1;
        end
        for (int off = 0; off <= fd; off++) begin
            @(posedge clock); #1;
            if (off == 0) begin
                frame_base = cyc;
                en_seq.delete();
                rise_q.delete();
                fd_count = 0;
                fd_off   = -1;
            end
            reset       = (off == rst_at);
            frame_start = (off == 0) || (off == ovr_at);
            client_req  = (off == 0) ? req : NC'($urandom);
            exp_en = '0; exp_vld = 1'b0; exp_idx = 0;
            for (int k = 0; k < NC; k++) begin
                if (req[k] && off >= gs[k] && off <= ge[k]) begin
                    exp_en[k] = 1'b1;
                    exp_vld   = 1'b1;
                    exp_idx   = k;
                end
            end
            drive_fields();
            for (int k = 0; k < NC; k++) begin
                if (!req[k])     client_done[k] = 1'($urandom_range(0, 1));
                else if (tmo[k]) client_done[k] = 1'b0;
                else             client_done[k] = (off >= gs[k] + fr_d[k]) && (off <= ge[k] + fr_h[k]);
            end
            if (wr_ng) client_write = ~exp_en;
            exp_busy = (off >= 1);
            exp_fd   = (off == fd);
            if (off == ovr_at && off >= 1 && ovr_cyc == INF) ovr_cyc = cyc + 1;
            for (int k = 0; k < NC; k++) begin
                if (tmo[k] && off == ge[k] && to_cyc == INF) to_cyc = cyc + 1;
            end
            if (off == rst_at) break;
        end
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; client_req = '0; client_done = '0;
        client_x = '0; client_y = '0; client_colour = '0; client_write = '0;
        exp_en = '0; exp_vld = 1'b0; exp_idx = 0; exp_busy = 1'b0; exp_fd = 1'b0;
        fd_count = 0; fd_off = -1; frame_base = 0;
        @(posedge clock); #1;
        cmp_en = 1'b1;
        @(posedge clock); #1;
        check("reset_enable",     64'(client_enable), 64'(0));
        check("reset_busy",       64'(busy),          64'(0));
        check("reset_frame_done", 64'(frame_done),    64'(0));
        check("reset_overrun",    64'(overrun),       64'(0));
        check("reset_timeout",    64'(timeout_err),   64'(0));
        idle(2, 1'b0);

        // Map then HUD, long map grant stays under the watchdog
        clear_plan(); fr_d[0] = 4097; fr_d[5] = 10;
        run_frame(6'b100001, -1, -1, 1'b0); idle(1, 1'b0);
        check("mh_grants",   64'(en_seq.size()), 64'(2));
        check("mh_first",    64'(en_seq[0]),     64'(6'b000001));
        check("mh_second",   64'(en_seq[1]),     64'(6'b100000));
        check("mh_hud_rise", 64'(rise_q[1]),     64'(4102));
        check("mh_fd_count", 64'(fd_count),      64'(1));
        check("mh_fd_off",   64'(fd_off),        64'(4115));
        check("mh_timeout",  64'(timeout_err),   64'(0));

        // Empty request
        clear_plan();
        run_frame(6'b000000, -1, -1, 1'b0); idle(1, 1'b0);
        check("empty_fd_off", 64'(fd_off),        64'(2));
        check("empty_grants", 64'(en_seq.size()), 64'(0));
        check("empty_fd_cnt", 64'(fd_count),      64'(1));

        // Sprite 2 never finishes: watchdog abort, then HUD
        clear_plan(); fr_d[3] = -1; fr_d[5] = 10;
        run_frame(6'b101000, -1, -1, 1'b0); idle(1, 1'b0);
        check("to_flag",     64'(timeout_err), 64'(1));
        check("to_first",    64'(en_seq[0]),   64'(6'b001000));
        check("to_second",   64'(en_seq[1]),   64'(6'b100000));
        check("to_hud_rise", 64'(rise_q[1]),   64'(65539));

        // frame_start during a grant
        clear_plan(); fr_d[1] = 20; fr_d[2] = 6;
        run_frame(6'b000110, 4, -1, 1'b0); idle(1, 1'b0);
        check("ovr_flag",   64'(overrun),       64'(1));
        check("ovr_fd_cnt", 64'(fd_count),      64'(1));
        check("ovr_grants", 64'(en_seq.size()), 64'(2));
        check("ovr_first",  64'(en_seq[0]),     64'(6'b000010));
        check("ovr_second", 64'(en_seq[1]),     64'(6'b000100));

        // Done held 3 cycles past enable drop
        clear_plan(); fr_d[0] = 5; fr_h[0] = 3; fr_d[1] = 4;
        run_frame(6'b000011, -1, -1, 1'b0); idle(1, 1'b0);
        check("hold_rise0", 64'(rise_q[0]), 64'(2));
        check("hold_rise1", 64'(rise_q[1]), 64'(13));

        // Reset clears the sticky flags
        @(posedge clock); #1;
        reset = 1'b1;
        idle(2, 1'b1);
        check("clr_overrun", 64'(overrun),     64'(0));
        check("clr_timeout", 64'(timeout_err), 64'(0));

        // Randomized frames
        repeat (40) begin
            clear_plan();
            for (int k = 0; k < NC; k++) begin
                fr_d[k] = int'($urandom_range(0, 30));
                fr_h[k] = int'($urandom_range(0, 4));
            end
            run_frame(NC'($urandom), -2, -1, 1'b0);
            idle(int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset in the middle of a grant, other clients writing
        clear_plan(); fr_d[1] = 20; fr_d[2] = 3;
        run_frame(6'b000110, -1, 6, 1'b1);
        idle(3, 1'b1);
        check("mid_rst_enable", 64'(client_enable), 64'(0));
        check("mid_rst_busy",   64'(busy),          64'(0));

        // Old pending work is gone after the reset
        clear_plan(); fr_d[0] = 3;
        run_frame(6'b000001, -1, -1, 1'b0); idle(1, 1'b0);
        check("post_rst_grants", 64'(en_seq.size()), 64'(1));
        check("post_rst_fd_cnt", 64'(fd_count),      64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
